// File: rtl/mul_wb_queue.sv
// Completion buffer for the fixed-latency multiplier: queues every result and drains it to the
// writeback bus, while issue credits keep a completion from ever meeting a full FIFO.
module mul_wb_queue #(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned LG_DEPTH       = 3,
  parameter int unsigned M_WIDTH        = 64,
  parameter int unsigned LG_ROB_ENTRIES = 6,
  parameter int unsigned LG_PRF_ENTRIES = 7
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      issue_go,
  output logic                      can_issue,
  input  logic                      mul_complete,
  input  logic [M_WIDTH-1:0]        mul_y,
  input  logic [LG_ROB_ENTRIES-1:0] mul_rob_ptr,
  input  logic                      mul_prf_ptr_val,
  input  logic [LG_PRF_ENTRIES-1:0] mul_prf_ptr,
  output logic                      wb_valid,
  input  logic                      wb_ready,
  output logic [M_WIDTH-1:0]        wb_data,
  output logic [LG_ROB_ENTRIES-1:0] wb_rob_ptr,
  output logic                      wb_prf_ptr_val,
  output logic [LG_PRF_ENTRIES-1:0] wb_prf_ptr,
  output logic                      err
);

  localparam int unsigned EntryW = M_WIDTH + LG_ROB_ENTRIES + 1 + LG_PRF_ENTRIES;
  localparam logic [LG_DEPTH:0] CountFull = DEPTH[LG_DEPTH:0];
  localparam logic [LG_DEPTH:0] InflMax = '1;

  logic [EntryW-1:0]   r_mem [DEPTH];
  logic [LG_DEPTH-1:0] r_rd_ptr;
  logic [LG_DEPTH-1:0] r_wr_ptr;
  logic [LG_DEPTH:0]   r_count;
  logic [LG_DEPTH:0]   r_inflight;
  logic                r_err;

  logic                w_full;
  logic                w_deq;
  logic                w_enq;
  logic                w_violation;
  logic [LG_DEPTH+1:0] w_credit_sum;
  logic [LG_DEPTH:0]   w_count_d;
  logic [LG_DEPTH:0]   w_inflight_d;

  assign w_full       = (r_count == CountFull);
  assign wb_valid     = (r_count != '0);
  assign w_deq        = wb_valid && wb_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the completion.
  assign w_enq        = mul_complete && (!w_full || w_deq);
  assign w_credit_sum = {1'b0, r_count} + {1'b0, r_inflight};
  assign can_issue    = (w_credit_sum < {1'b0, CountFull});
  assign err          = r_err;

  assign {wb_data, wb_rob_ptr, wb_prf_ptr_val, wb_prf_ptr} = r_mem[r_rd_ptr];

  assign w_violation = (mul_complete && w_full && !w_deq) ||
                       (issue_go && !can_issue) ||
                       (mul_complete && !issue_go && (r_inflight == '0));

  always_comb begin
    w_count_d = r_count;
    unique case ({w_enq, w_deq})
      2'b10:   w_count_d = r_count + 1'b1;
      2'b01:   w_count_d = r_count - 1'b1;
      default: w_count_d = r_count;
    endcase
  end

  always_comb begin
    w_inflight_d = r_inflight;
    if (issue_go && !mul_complete && (r_inflight != InflMax)) begin
      w_inflight_d = r_inflight + 1'b1;
    end else if (mul_complete && !issue_go && (r_inflight != '0)) begin
      w_inflight_d = r_inflight - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_inflight <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count    <= w_count_d;
      r_inflight <= w_inflight_d;
      if (w_violation) r_err <= 1'b1;
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem[r_wr_ptr] <= {mul_y, mul_rob_ptr, mul_prf_ptr_val, mul_prf_ptr};
    end
  end

endmodule

// File: tb/tb_mul_wb_queue.sv
// Bench for mul_wb_queue: directed scenarios plus randomized traffic, all scored against a
// queue-based model of the buffer, credit counter and sticky error flag.
module tb_mul_wb_queue;

  localparam int unsigned Depth = 8;
  localparam int unsigned MW = 64;
  localparam int unsigned RW = 6;
  localparam int unsigned PW = 7;
  localparam int unsigned EW = MW + RW + 1 + PW;
  localparam int unsigned Lat = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          issue_go = 1'b0;
  logic          can_issue;
  logic          mul_complete = 1'b0;
  logic [MW-1:0] mul_y = '0;
  logic [RW-1:0] mul_rob_ptr = '0;
  logic          mul_prf_ptr_val = 1'b0;
  logic [PW-1:0] mul_prf_ptr = '0;
  logic          wb_valid;
  logic          wb_ready = 1'b0;
  logic [MW-1:0] wb_data;
  logic [RW-1:0] wb_rob_ptr;
  logic          wb_prf_ptr_val;
  logic [PW-1:0] wb_prf_ptr;
  logic          err;

  always #5 clk = ~clk;

  mul_wb_queue #(
    .DEPTH(Depth), .LG_DEPTH(3), .M_WIDTH(MW), .LG_ROB_ENTRIES(RW), .LG_PRF_ENTRIES(PW)
  ) u_dut (
    .clk(clk), .reset(reset), .issue_go(issue_go), .can_issue(can_issue),
    .mul_complete(mul_complete), .mul_y(mul_y), .mul_rob_ptr(mul_rob_ptr),
    .mul_prf_ptr_val(mul_prf_ptr_val), .mul_prf_ptr(mul_prf_ptr),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rob_ptr(wb_rob_ptr),
    .wb_prf_ptr_val(wb_prf_ptr_val), .wb_prf_ptr(wb_prf_ptr), .err(err)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  // Reference model: the FIFO contents, outstanding multiplies and the sticky error.
  logic [EW-1:0] m_q[$];
  int            m_infl = 0;
  bit            m_err = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit model_can();
    return (m_q.size() + m_infl) < Depth;
  endfunction

  function automatic logic [EW-1:0] ent_of(input int k);
    logic [MW-1:0] y;
    y = {32'(k), 32'hC0DE_0000 | 32'(k)};
    return {y, RW'(k), 1'(k), PW'(k + 3)};
  endfunction

  function automatic logic [EW-1:0] rnd_ent();
    return {$urandom, $urandom, RW'($urandom), 1'($urandom), PW'($urandom)};
  endfunction

  task automatic model_step(input logic rst, input logic go, input logic comp,
                            input logic rdy, input logic [EW-1:0] ent);
    bit deq;
    bit full;
    bit can;
    if (rst) begin
      m_q.delete();
      m_infl = 0;
      m_err = 1'b0;
      return;
    end
    deq  = (m_q.size() != 0) && rdy;
    full = (m_q.size() == Depth);
    can  = model_can();
    if (comp && full && !deq) m_err = 1'b1;
    if (go && !can) m_err = 1'b1;
    if (comp && m_infl == 0 && !go) m_err = 1'b1;
    if (deq) void'(m_q.pop_front());
    if (comp && (!full || deq)) m_q.push_back(ent);
    if (go && !comp && m_infl < 15) m_infl++;
    else if (comp && !go && m_infl > 0) m_infl--;
  endtask

  task automatic compare_all();
    check("wb_valid", wb_valid, m_q.size() != 0);
    check("can_issue", can_issue, model_can());
    check("err", err, m_err);
    if (m_q.size() != 0) begin
      check("payload", {wb_data, wb_rob_ptr, wb_prf_ptr_val, wb_prf_ptr}, m_q[0]);
    end
  endtask

  // One clock: drive at the falling edge, step the model at the rising edge, score afterwards.
  task automatic cyc(input logic rst, input logic go, input logic comp, input logic rdy,
                     input logic [EW-1:0] ent);
    reset = rst;
    issue_go = go;
    mul_complete = comp;
    wb_ready = rdy;
    {mul_y, mul_rob_ptr, mul_prf_ptr_val, mul_prf_ptr} = ent;
    @(posedge clk);
    model_step(rst, go, comp, rdy, ent);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_rst();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    logic [Lat-1:0] pipe;
    logic           go;
    logic           rdy;
    @(negedge clk);

    // Reset, then one issue and one completion.
    idle_rst();
    idle_rst();
    check("rst_valid", wb_valid, 1'b0);
    check("rst_can", can_issue, 1'b1);
    check("rst_err", err, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, {64'h1234, RW'(1), 1'b1, PW'(2)});
    check("first_valid", wb_valid, 1'b1);
    check("first_data", wb_data, 64'h1234);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, '0);
    check("first_drained", wb_valid, 1'b0);

    // Credit fill with the bus stalled, then drain in order.
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("can_before_8th", can_issue, 1'b1);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    end
    check("can_after_8", can_issue, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, ent_of(i));
    check("fill_err", err, 1'b0);
    check("fill_can", can_issue, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check("drain_order", wb_rob_ptr, RW'(i));
      cyc(1'b0, 1'b0, 1'b0, 1'b1, '0);
      if (i == 0) check("can_after_pop", can_issue, 1'b1);
    end

    // Stall hold on rob 5, then one pulse of ready.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, ent_of(5));
    cyc(1'b0, 1'b0, 1'b1, 1'b0, ent_of(6));
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
      check("stall_valid", wb_valid, 1'b1);
      check("stall_rob", wb_rob_ptr, RW'(5));
      check("stall_data", wb_data, ent_of(5) >> (EW - MW));
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, '0);
    check("stall_adv", wb_rob_ptr, RW'(6));
    cyc(1'b0, 1'b0, 1'b0, 1'b1, '0);

    // Steady state near capacity: issue, complete and pop every cycle so pointers wrap.
    idle_rst();
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, ent_of(i));
    for (int i = 6; i < 26; i++) begin
      check("wrap_rob", wb_rob_ptr, RW'(i - 6));
      cyc(1'b0, 1'b1, 1'b1, 1'b1, ent_of(i));
    end
    check("wrap_err", err, 1'b0);

    // Overflow: completion into a full FIFO with no pop is dropped and flags err.
    idle_rst();
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, ent_of(i));
    check("full_err0", err, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, ent_of(40));
    check("drop_err", err, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check("drop_order", wb_rob_ptr, RW'(i));
      cyc(1'b0, 1'b0, 1'b0, 1'b1, '0);
    end
    check("drop_empty", wb_valid, 1'b0);
    check("drop_sticky", err, 1'b1);
    idle_rst();
    check("err_cleared", err, 1'b0);

    // Reset mid-flight discards queued and outstanding work.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, ent_of(i));
    idle_rst();
    check("mid_valid", wb_valid, 1'b0);
    check("mid_can", can_issue, 1'b1);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    check("mid_infl_zero", can_issue, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    check("mid_can_8", can_issue, 1'b0);

    // Randomized legal traffic through a fixed-latency multiplier stand-in.
    idle_rst();
    pipe = '0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        idle_rst();
        pipe = '0;
      end else begin
        go  = model_can() && ($urandom_range(0, 2) != 0);
        rdy = ($urandom_range(0, 3) != 0);
        cyc(1'b0, go, pipe[Lat-1], rdy, rnd_ent());
        pipe = {pipe[Lat-2:0], go};
      end
    end
    check("rand_err", err, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
